// File: rtl/recovery_pkg.sv
// Shared state encoding and default timing parameters for the fault-recovery sequencer.
package recovery_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    RESTORE,
    REPLAY,
    FATAL
  } rec_state_e;

  localparam int unsigned DEF_FLUSH_CYCLES  = 3;
  localparam int unsigned DEF_REPLAY_CYCLES = 8;
  localparam int unsigned DEF_MAX_RETRIES   = 3;
  localparam int unsigned DEF_CLEAN_CYCLES  = 64;
  localparam int unsigned DEF_ACK_TIMEOUT   = 16;

endpackage

// File: rtl/recovery_ctrl_if.sv
// Checker/pipeline-facing signal bundle of recovery_ctrl; master drives requests, slave is the sequencer.
interface recovery_ctrl_if #(
  parameter int unsigned RC_W = 2
);
  logic            fault_detect;
  logic            pc_write_req;
  logic            reg_write_req;
  logic            mem_write_req;
  logic            restore_ack;
  logic            pc_write;
  logic            reg_write;
  logic            mem_write;
  logic            recovery_active;
  logic            pipe_flush;
  logic            restore_req;
  logic            fatal_error;
  logic [RC_W-1:0] retry_count;

  modport master (
    output fault_detect, pc_write_req, reg_write_req, mem_write_req, restore_ack,
    input  pc_write, reg_write, mem_write, recovery_active, pipe_flush, restore_req,
           fatal_error, retry_count
  );

  modport slave (
    input  fault_detect, pc_write_req, reg_write_req, mem_write_req, restore_ack,
    output pc_write, reg_write, mem_write, recovery_active, pipe_flush, restore_req,
           fatal_error, retry_count
  );
endinterface

// File: rtl/rec_down_counter.sv
// Loadable down counter that holds at zero; used for the flush, ack-timeout and replay timers.
module rec_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             zero
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)                   count <= '0;
    else if (load)               count <= load_value;
    else if (en && count != '0)  count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/recovery_ctrl.sv
// Fault-recovery sequencer: gates commit writes, flushes, requests restore, then runs a guarded replay.
module recovery_ctrl
  import recovery_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES  = DEF_FLUSH_CYCLES,
  parameter int unsigned REPLAY_CYCLES = DEF_REPLAY_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int unsigned CLEAN_CYCLES  = DEF_CLEAN_CYCLES,
  parameter int unsigned ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  recovery_ctrl_if.slave  bus
);
  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned PW = $clog2(REPLAY_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
  localparam int unsigned CW = $clog2(CLEAN_CYCLES + 1);

  rec_state_e    state, state_next;
  logic [RW-1:0] retry_q, retry_next;
  logic [CW-1:0] clean_q, clean_next;
  logic          flush_ld, flush_en, flush_zero;
  logic          ack_ld, ack_en, ack_zero;
  logic          rep_ld, rep_en, rep_zero;
  logic          idle;

  rec_down_counter #(.WIDTH(FW)) u_flush_tmr (
    .clk(clk), .reset(reset), .load(flush_ld), .load_value(FW'(FLUSH_CYCLES - 1)),
    .en(flush_en), .zero(flush_zero)
  );

  rec_down_counter #(.WIDTH(AW)) u_ack_tmr (
    .clk(clk), .reset(reset), .load(ack_ld), .load_value(AW'(ACK_TIMEOUT - 1)),
    .en(ack_en), .zero(ack_zero)
  );

  rec_down_counter #(.WIDTH(PW)) u_replay_tmr (
    .clk(clk), .reset(reset), .load(rep_ld), .load_value(PW'(REPLAY_CYCLES - 1)),
    .en(rep_en), .zero(rep_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      retry_q <= '0;
      clean_q <= '0;
    end else begin
      state   <= state_next;
      retry_q <= retry_next;
      clean_q <= clean_next;
    end
  end

  always_comb begin
    state_next = state;
    retry_next = retry_q;
    clean_next = clean_q;
    flush_ld   = 1'b0;
    flush_en   = 1'b0;
    ack_ld     = 1'b0;
    ack_en     = 1'b0;
    rep_ld     = 1'b0;
    rep_en     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.fault_detect) begin
          clean_next = '0;
          if (retry_q == RW'(MAX_RETRIES)) begin
            state_next = FATAL;
          end else begin
            retry_next = retry_q + 1'b1;
            state_next = FLUSH;
            flush_ld   = 1'b1;
          end
        end else if (clean_q != CW'(CLEAN_CYCLES)) begin
          // Clean counter saturates; retries clear on the cycle it reaches the window length.
          clean_next = clean_q + 1'b1;
          if (clean_next == CW'(CLEAN_CYCLES)) retry_next = '0;
        end
      end
      FLUSH: begin
        if (flush_zero) begin
          state_next = RESTORE;
          ack_ld     = 1'b1;
        end else begin
          flush_en = 1'b1;
        end
      end
      RESTORE: begin
        if (bus.restore_ack) begin
          state_next = REPLAY;
          rep_ld     = 1'b1;
        end else if (ack_zero) begin
          state_next = FATAL;
        end else begin
          ack_en = 1'b1;
        end
      end
      REPLAY: begin
        if (bus.fault_detect) begin
          if (retry_q == RW'(MAX_RETRIES)) begin
            state_next = FATAL;
          end else begin
            retry_next = retry_q + 1'b1;
            state_next = FLUSH;
            flush_ld   = 1'b1;
          end
        end else if (rep_zero) begin
          state_next = IDLE;
        end else begin
          rep_en = 1'b1;
        end
      end
      FATAL:   state_next = FATAL;
      default: state_next = IDLE;
    endcase
  end

  assign idle                = (state == IDLE);
  assign bus.pc_write        = bus.pc_write_req  & idle & ~bus.fault_detect;
  assign bus.reg_write       = bus.reg_write_req & idle & ~bus.fault_detect;
  assign bus.mem_write       = bus.mem_write_req & idle & ~bus.fault_detect;
  assign bus.recovery_active = ~idle;
  assign bus.pipe_flush      = (state == FLUSH) || (state == FATAL);
  assign bus.restore_req     = (state == RESTORE);
  assign bus.fatal_error     = (state == FATAL);
  assign bus.retry_count     = retry_q;
endmodule

// File: tb/tb_recovery_ctrl.sv
// Self-checking bench for recovery_ctrl: directed vector table, corner sequences, random vs reference model.
module tb_recovery_ctrl;
  localparam int FLUSH_N = 3;
  localparam int REPLAY_N = 8;
  localparam int MAX_R = 3;
  localparam int CLEAN_N = 64;
  localparam int ACK_N = 16;
  localparam int M_IDLE = 0, M_FLUSH = 1, M_RESTORE = 2, M_REPLAY = 3, M_FATAL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  recovery_ctrl_if #(.RC_W(2)) bus ();

  recovery_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: current phase, cycles spent in it, fault-free IDLE run length, retries.
  int m_mode = M_IDLE;
  int m_elapsed = 0;
  int m_clean = 0;
  int m_retries = 0;

  typedef struct {
    logic       f, pcr, rgr, mr, ack;
    logic [6:0] exp;   // {pc, reg, mem, active, flush, req, fatal}
    logic [1:0] rc;
  } vec_t;
  vec_t tbl [19];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_outs();
    return {bus.pc_write, bus.reg_write, bus.mem_write, bus.recovery_active,
            bus.pipe_flush, bus.restore_req, bus.fatal_error};
  endfunction

  task automatic enter(input int mode);
    m_mode = mode;
    m_elapsed = 0;
  endtask

  task automatic take_fault();
    if (m_retries == MAX_R) enter(M_FATAL);
    else begin
      m_retries++;
      enter(M_FLUSH);
    end
  endtask

  task automatic model_step(input logic r, input logic f, input logic a);
    if (r) begin
      enter(M_IDLE);
      m_clean = 0;
      m_retries = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (f) begin
          m_clean = 0;
          take_fault();
        end else begin
          m_clean++;
          if (m_clean >= CLEAN_N) m_retries = 0;
        end
        M_FLUSH:   if (m_elapsed + 1 == FLUSH_N) enter(M_RESTORE); else m_elapsed++;
        M_RESTORE: if (a) enter(M_REPLAY);
                   else if (m_elapsed + 1 == ACK_N) enter(M_FATAL);
                   else m_elapsed++;
        M_REPLAY:  if (f) take_fault();
                   else if (m_elapsed + 1 == REPLAY_N) enter(M_IDLE);
                   else m_elapsed++;
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic pcr, input logic rgr,
                       input logic mr, input logic a);
    reset = r;
    bus.fault_detect = f;
    bus.pc_write_req = pcr;
    bus.reg_write_req = rgr;
    bus.mem_write_req = mr;
    bus.restore_ack = a;
    #1;
  endtask

  // Compare against the model, advance the model and the clock; returns at edge+1.
  task automatic tick(input bit chk);
    logic       idle;
    logic [6:0] exp;
    idle = (m_mode == M_IDLE);
    exp = {bus.pc_write_req & idle & ~bus.fault_detect,
           bus.reg_write_req & idle & ~bus.fault_detect,
           bus.mem_write_req & idle & ~bus.fault_detect,
           m_mode != M_IDLE, (m_mode == M_FLUSH) || (m_mode == M_FATAL),
           m_mode == M_RESTORE, m_mode == M_FATAL};
    if (chk) begin
      check("model_outs", {1'b0, dut_outs()}, {1'b0, exp});
      check("model_retry", {6'd0, bus.retry_count}, 8'(m_retries));
    end
    model_step(reset, bus.fault_detect, bus.restore_ack);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic r, input logic f, input logic a);
    drive(r, f, 1'b1, 1'b1, 1'b1, a);
    tick(1'b1);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1110000, 2'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0000000, 2'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0001100, 2'd1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0001100, 2'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001100, 2'd1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0001010, 2'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001010, 2'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0001010, 2'd1};
    for (int i = 8; i < 16; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0001000, 2'd1};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1110000, 2'd1};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 7'b1010000, 2'd1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'd1};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0);
    check("reset_outs", {1'b0, dut_outs()}, 8'b0);
    check("reset_retry", {6'd0, bus.retry_count}, 8'd0);

    // Directed table: gating, same-cycle fault kill, 3-cycle flush, ack after 2, 8-cycle replay.
    for (int i = 0; i < 19; i++) begin
      drive(1'b0, tbl[i].f, tbl[i].pcr, tbl[i].rgr, tbl[i].mr, tbl[i].ack);
      check($sformatf("tbl%0d_outs", i), {1'b0, dut_outs()}, {1'b0, tbl[i].exp});
      check($sformatf("tbl%0d_retry", i), {6'd0, bus.retry_count}, {6'd0, tbl[i].rc});
      tick(1'b1);
    end

    // Three fault-free IDLE cycles so far; 63 total must not clear, a fault then increments.
    quiet(60);
    check("retry_at_63", {6'd0, bus.retry_count}, 8'd1);
    cyc(1'b0, 1'b1, 1'b0);
    check("retry_fault_63", {6'd0, bus.retry_count}, 8'd2);
    quiet(FLUSH_N);
    cyc(1'b0, 1'b0, 1'b1);
    quiet(REPLAY_N);
    check("back_idle", {1'b0, dut_outs()}, 8'b01110000);
    quiet(63);
    check("retry_clean_63", {6'd0, bus.retry_count}, 8'd2);
    quiet(1);
    check("retry_clean_64", {6'd0, bus.retry_count}, 8'd0);

    // Repeated faults in REPLAY until retries are exhausted.
    cyc(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      quiet(FLUSH_N);
      cyc(1'b0, 1'b0, 1'b1);
      quiet(k);
      cyc(1'b0, 1'b1, 1'b0);
      if (k == 1) check("retry_three", {6'd0, bus.retry_count}, 8'd3);
    end
    check("fatal_retries", {1'b0, dut_outs()}, 8'b00001101);
    for (int i = 0; i < 5; i++) cyc(1'b0, i[0], 1'b1);
    check("fatal_sticky", {1'b0, dut_outs()}, 8'b00001101);
    cyc(1'b1, 1'b0, 1'b0);
    check("reset_from_fatal", {1'b0, dut_outs()}, 8'b01110000);
    check("reset_retry_fatal", {6'd0, bus.retry_count}, 8'd0);

    // Restore ack withheld: 16 RESTORE cycles then FATAL; faults ignored in FLUSH/RESTORE.
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < FLUSH_N + ACK_N - 1; i++) cyc(1'b0, i[1], 1'b0);
    check("req_last_wait", {1'b0, dut_outs()}, 8'b00001010);
    check("retry_ignored", {6'd0, bus.retry_count}, 8'd1);
    cyc(1'b0, 1'b0, 1'b0);
    check("fatal_timeout", {1'b0, dut_outs()}, 8'b00001101);
    cyc(1'b1, 1'b0, 1'b0);
    check("reset_timeout", {1'b0, dut_outs()}, 8'b01110000);

    // Reset in the middle of FLUSH.
    cyc(1'b0, 1'b1, 1'b0);
    quiet(2);
    cyc(1'b1, 1'b0, 1'b0);
    check("reset_mid_flush", {1'b0, dut_outs()}, 8'b01110000);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      logic r, f, a;
      r = ($urandom_range(0, 399) == 0);
      f = ((i % 500) >= 90) && ($urandom_range(0, 11) == 0);
      a = ($urandom_range(0, 3) == 0);
      drive(r, f, 1'($urandom), 1'($urandom), 1'($urandom), a);
      tick(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
